// File: rtl/ghost_navigator.sv
// Ghost maze navigation: legal-move mask from an on-chip maze map plus a
// target-seeking heading choice, both registered on Clk.
module ghost_navigator #(
    parameter string MAZE_FILE = "maze.mem",
    parameter int    MAZE_X0   = 72,
    parameter int    MAZE_Y0   = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] PosX,
    input  logic [9:0] PosY,
    input  logic       is_Ghost,
    input  logic [9:0] targetX,
    input  logic [9:0] targetY,
    input  logic [3:0] currentDirection,
    output logic [3:0] availible_dir,
    output logic [3:0] nextDirection
);

    localparam int COLS  = 28;
    localparam int ROWS  = 31;
    localparam int CELLS = COLS * ROWS;

    localparam logic signed [10:0] TILE = 11'sd12;
    localparam logic signed [10:0] HALF = 11'sd6;

    // Neighbour offsets indexed by mask bit: left, up, right, down
    localparam logic signed [10:0] DCOL [4] = '{-11'sd1, 11'sd0, 11'sd1, 11'sd0};
    localparam logic signed [10:0] DROW [4] = '{11'sd0, -11'sd1, 11'sd0, 11'sd1};

    genvar gi;

    logic [1:0] w_maze_rom [CELLS];

    generate
        // Walled border, open interior, one ghost door at column 5 row 4
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            localparam int ROW = gi / COLS;
            localparam int COL = gi % COLS;
            localparam bit BORDER = (ROW == 0) || (ROW == ROWS - 1) ||
                                    (COL == 0) || (COL == COLS - 1);
            assign w_maze_rom[gi] = BORDER ? 2'd1 :
                                    ((COL == 5) && (ROW == 4)) ? 2'd2 : 2'd0;
        end
    endgenerate

    function automatic logic signed [10:0] centre(input logic [9:0] pos, input int origin);
        return 11'({1'b0, pos} + 11'd12 - 11'(origin));
    endfunction

    // Rows outside the map are wall; columns -1 and 28 form the side tunnel
    function automatic logic cell_open(input logic signed [10:0] c,
                                       input logic signed [10:0] r,
                                       input logic               ghost);
        logic [9:0] idx;
        logic [1:0] code;
        idx       = 10'd0;
        code      = 2'd1;
        cell_open = 1'b0;
        if ((r >= 11'sd0) && (r <= 11'sd30)) begin
            if ((c == -11'sd1) || (c == 11'sd28)) begin
                cell_open = 1'b1;
            end else if ((c >= 11'sd0) && (c <= 11'sd27)) begin
                idx       = 10'(r[4:0]) * 10'd28 + 10'(c[4:0]);
                code      = w_maze_rom[idx];
                cell_open = (code == 2'd0) || ((code == 2'd2) && ghost);
            end
        end
    endfunction

    logic signed [10:0] w_cx, w_cy, w_tx, w_ty;
    logic signed [10:0] w_col, w_row, w_ox, w_oy;
    logic signed [10:0] w_tc, w_tr;
    logic               w_xcent, w_ycent, w_tunnel;

    assign w_cx  = centre(PosX, MAZE_X0);
    assign w_cy  = centre(PosY, MAZE_Y0);
    assign w_tx  = centre(targetX, MAZE_X0);
    assign w_ty  = centre(targetY, MAZE_Y0);
    assign w_col = w_cx / TILE;
    assign w_row = w_cy / TILE;
    assign w_ox  = w_cx % TILE;
    assign w_oy  = w_cy % TILE;
    assign w_tc  = w_tx / TILE;
    assign w_tr  = w_ty / TILE;

    assign w_xcent  = (w_ox == HALF);
    assign w_ycent  = (w_oy == HALF);
    assign w_tunnel = (w_cx < 11'sd0) || (w_col >= 11'sd28);

    logic signed [10:0] w_nc [4];
    logic signed [10:0] w_nr [4];
    logic [15:0]        w_score [4];
    logic [3:0]         w_nb_open;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_dir
            logic signed [7:0]  w_dc, w_dr;
            logic signed [15:0] w_dc16, w_dr16;
            assign w_nc[gi]      = w_col + DCOL[gi];
            assign w_nr[gi]      = w_row + DROW[gi];
            assign w_nb_open[gi] = cell_open(w_nc[gi], w_nr[gi], is_Ghost);
            assign w_dc          = 8'(w_nc[gi] - w_tc);
            assign w_dr          = 8'(w_nr[gi] - w_tr);
            assign w_dc16        = 16'(w_dc);
            assign w_dr16        = 16'(w_dr);
            assign w_score[gi]   = 16'(w_dc16 * w_dc16) + 16'(w_dr16 * w_dr16);
        end
    endgenerate

    // While still inside a tile, movement away from its centre stays legal
    logic [3:0] w_legal;
    assign w_legal[0] = w_ycent && ((w_ox > HALF) || w_nb_open[0]);
    assign w_legal[1] = w_xcent && ((w_oy > HALF) || w_nb_open[1]);
    assign w_legal[2] = w_ycent && ((w_ox < HALF) || w_nb_open[2]);
    assign w_legal[3] = w_xcent && ((w_oy < HALF) || w_nb_open[3]);

    logic [3:0] w_rev_code;
    logic [3:0] w_rev_mask;

    always_comb begin
        w_rev_code = 4'd0;
        w_rev_mask = 4'b0000;
        case (currentDirection)
            4'd1: begin w_rev_code = 4'd3; w_rev_mask = 4'b0100; end
            4'd2: begin w_rev_code = 4'd4; w_rev_mask = 4'b1000; end
            4'd3: begin w_rev_code = 4'd1; w_rev_mask = 4'b0001; end
            4'd4: begin w_rev_code = 4'd2; w_rev_mask = 4'b0010; end
            default: ;
        endcase
    end

    logic [3:0] w_cand;
    assign w_cand = w_legal & ~w_rev_mask;

    // Strict less-than keeps the earlier entry on ties: up, left, down, right
    logic [4:0]  w_chain_found;
    logic [15:0] w_chain_score [5];
    logic [3:0]  w_chain_code  [5];

    assign w_chain_found[0] = 1'b0;
    assign w_chain_score[0] = 16'hFFFF;
    assign w_chain_code[0]  = 4'd0;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_pick
            localparam int K = (gi == 0) ? 1 : (gi == 1) ? 0 : (gi == 2) ? 3 : 2;
            logic w_take;
            assign w_take = w_cand[K] &&
                            (!w_chain_found[gi] || (w_score[K] < w_chain_score[gi]));
            assign w_chain_found[gi+1] = w_chain_found[gi] | w_take;
            assign w_chain_score[gi+1] = w_take ? w_score[K] : w_chain_score[gi];
            assign w_chain_code[gi+1]  = w_take ? 4'(K + 1) : w_chain_code[gi];
        end
    endgenerate

    logic [3:0] w_pick;
    logic [3:0] w_avail;
    logic [3:0] w_next;

    assign w_pick  = w_chain_found[4]           ? w_chain_code[4] :
                     (|(w_legal & w_rev_mask)) ? w_rev_code      : 4'd0;
    assign w_avail = w_tunnel ? 4'b0101 : w_legal;
    assign w_next  = (!w_tunnel && w_xcent && w_ycent) ? w_pick : currentDirection;

    logic [3:0] r_avail;
    logic [3:0] r_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_avail <= 4'd0;
            r_next  <= 4'd0;
        end else begin
            r_avail <= w_avail;
            r_next  <= w_next;
        end
    end

    assign availible_dir = r_avail;
    assign nextDirection = r_next;

endmodule

// File: tb/tb_ghost_navigator.sv
// Directed and randomized checks of ghost_navigator against a tile-level
// reference model of the test maze.
module tb_ghost_navigator;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] PosX, PosY, targetX, targetY;
    logic       is_Ghost;
    logic [3:0] currentDirection;
    logic [3:0] availible_dir;
    logic [3:0] nextDirection;

    int n_cmp = 0;
    int n_mis = 0;

    always #10 Clk = ~Clk;

    ghost_navigator #(
        .MAZE_FILE (""),
        .MAZE_X0   (72),
        .MAZE_Y0   (0)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .PosX             (PosX),
        .PosY             (PosY),
        .is_Ghost         (is_Ghost),
        .targetX          (targetX),
        .targetY          (targetY),
        .currentDirection (currentDirection),
        .availible_dir    (availible_dir),
        .nextDirection    (nextDirection)
    );

    function automatic int to_s11(int v);
        int w;
        w = v & 32'h7FF;
        if (w >= 1024) w = w - 2048;
        return w;
    endfunction

    function automatic int maze_code(int c, int r);
        if (r == 0 || r == 30 || c == 0 || c == 27) return 1;
        if (c == 5 && r == 4) return 2;
        return 0;
    endfunction

    function automatic bit open_at(int c, int r, bit g);
        int code;
        if (r < 0 || r > 30) return 1'b0;
        if (c == -1 || c == 28) return 1'b1;
        if (c < 0 || c > 27) return 1'b0;
        code = maze_code(c, r);
        return (code == 0) || (code == 2 && g);
    endfunction

    // Returns {availible_dir, nextDirection} expected one edge after these inputs
    function automatic logic [7:0] ref_model(int px, int py, int tx, int ty, bit g, int cur);
        int cx, cy, col, row, ox, oy, tc, tr, rev, best, best_score, d, nc, nr, score;
        logic [3:0] legal;
        cx  = to_s11(px + 12 - 72);
        cy  = to_s11(py + 12);
        col = cx / 12;
        row = cy / 12;
        ox  = cx % 12;
        oy  = cy % 12;
        if (cx < 0 || col >= 28) return {4'b0101, 4'(cur)};
        tc = to_s11(tx + 12 - 72) / 12;
        tr = to_s11(ty + 12) / 12;
        legal[0] = (oy == 6) && (ox > 6 || open_at(col - 1, row, g));
        legal[1] = (ox == 6) && (oy > 6 || open_at(col, row - 1, g));
        legal[2] = (oy == 6) && (ox < 6 || open_at(col + 1, row, g));
        legal[3] = (ox == 6) && (oy < 6 || open_at(col, row + 1, g));
        if (!(ox == 6 && oy == 6)) return {legal, 4'(cur)};
        rev = (cur == 1) ? 3 : (cur == 2) ? 4 : (cur == 3) ? 1 : (cur == 4) ? 2 : 0;
        best = 0;
        best_score = -1;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : 3;
            if (d != rev && legal[2'(d - 1)]) begin
                nc = col + ((d == 1) ? -1 : (d == 3) ? 1 : 0);
                nr = row + ((d == 2) ? -1 : (d == 4) ? 1 : 0);
                score = (nc - tc) * (nc - tc) + (nr - tr) * (nr - tr);
                if (best_score < 0 || score < best_score) begin
                    best = d;
                    best_score = score;
                end
            end
        end
        if (best == 0 && rev != 0 && legal[2'(rev - 1)]) best = rev;
        return {legal, 4'(best)};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input int px, input int py, input int tx,
                        input int ty, input logic g, input int cur);
        Reset            = rst;
        PosX             = 10'(px);
        PosY             = 10'(py);
        targetX          = 10'(tx);
        targetY          = 10'(ty);
        is_Ghost         = g;
        currentDirection = 4'(cur);
        @(posedge Clk);
        #1;
        $display("rst=%0d pos=(%0d,%0d) tgt=(%0d,%0d) ghost=%0d cur=%0d -> avail=%b next=%0d",
                 rst, px, py, tx, ty, g, cur, availible_dir, nextDirection);
    endtask

    logic [7:0] exp_v;

    initial begin
        Reset = 1'b1; PosX = '0; PosY = '0; targetX = '0; targetY = '0;
        is_Ghost = 1'b0; currentDirection = '0;

        // Reset with arbitrary inputs, held for two edges
        step(1'b1, 126, 54, 500, 300, 1'b1, 3);
        check("reset_avail", availible_dir, 4'b0000);
        check("reset_next", nextDirection, 4'd0);
        step(1'b1, 78, 6, 90, 18, 1'b0, 2);
        check("reset_hold_avail", availible_dir, 4'b0000);
        check("reset_hold_next", nextDirection, 4'd0);

        // Corner tile (1,1), heading up
        step(1'b0, 78, 6, 0, 0, 1'b0, 2);
        check("corner_avail", availible_dir, 4'b1100);
        check("corner_next", nextDirection, 4'd3);

        // Mid-corridor, not at a decision point
        step(1'b0, 81, 6, 0, 0, 1'b0, 3);
        check("corridor_avail", availible_dir, 4'b0101);
        check("corridor_next", nextDirection, 4'd3);

        // Four-way at tile (5,5), heading left
        step(1'b0, 126, 54, 126, 6, 1'b1, 1);
        check("fourway_avail", availible_dir, 4'b1111);
        check("fourway_up", nextDirection, 4'd2);
        step(1'b0, 126, 54, 126, 54, 1'b1, 1);
        check("fourway_tie", nextDirection, 4'd2);
        step(1'b0, 126, 54, 90, 54, 1'b1, 1);
        check("fourway_left", nextDirection, 4'd1);

        // Door above tile (5,5)
        step(1'b0, 126, 54, 126, 54, 1'b0, 4);
        check("door_pacman_bit1", 4'(availible_dir[1]), 4'd0);
        check("door_pacman_avail", availible_dir, 4'b1101);
        check("door_pacman_next", nextDirection, 4'd1);
        step(1'b0, 126, 54, 126, 54, 1'b1, 4);
        check("door_ghost_bit1", 4'(availible_dir[1]), 4'd1);

        // Tunnel on both sides of the map
        step(1'b0, 40, 6, 0, 0, 1'b0, 1);
        check("tunnel_l_avail", availible_dir, 4'b0101);
        check("tunnel_l_next", nextDirection, 4'd1);
        step(1'b0, 1000, 6, 0, 0, 1'b0, 1);
        check("tunnel_r_avail", availible_dir, 4'b0101);
        check("tunnel_r_next", nextDirection, 4'd1);

        // Reverse exclusion versus unknown heading, and the down/right tie
        step(1'b0, 78, 6, 186, 6, 1'b0, 1);
        check("rev_excluded", nextDirection, 4'd4);
        step(1'b0, 78, 6, 186, 6, 1'b0, 13);
        check("unknown_dir", nextDirection, 4'd3);
        step(1'b0, 78, 6, 90, 18, 1'b0, 9);
        check("tie_down_right", nextDirection, 4'd4);

        // Dead end where only the reverse is legal, then no legal move
        step(1'b0, 78, 354, 0, 0, 1'b0, 4);
        check("deadend_avail", availible_dir, 4'b0010);
        check("deadend_next", nextDirection, 4'd2);
        step(1'b0, 126, 378, 0, 0, 1'b0, 3);
        check("boxed_avail", availible_dir, 4'b0000);
        check("boxed_next", nextDirection, 4'd0);

        // Reset mid-operation, then recovery
        step(1'b1, 126, 54, 126, 6, 1'b1, 1);
        check("midreset_avail", availible_dir, 4'b0000);
        check("midreset_next", nextDirection, 4'd0);
        step(1'b0, 126, 54, 126, 6, 1'b1, 1);
        check("recover_avail", availible_dir, 4'b1111);
        check("recover_next", nextDirection, 4'd2);

        // Randomized traffic against the reference model
        for (int n = 0; n < 250; n++) begin
            int px, py, tx, ty, cur, col, row, off;
            logic rst;
            logic g;
            if ($urandom_range(0, 9) == 0) begin
                px = $urandom_range(0, 1023);
            end else begin
                col = $urandom_range(0, 27);
                off = $urandom_range(0, 1) ? 6 : $urandom_range(0, 11);
                px  = 60 + col * 12 + off;
            end
            row = $urandom_range(1, 31);
            off = $urandom_range(0, 1) ? 6 : $urandom_range(0, 11);
            py  = row * 12 + off - 12;
            tx  = $urandom_range(0, 1023);
            ty  = $urandom_range(0, 1023);
            g   = 1'($urandom_range(0, 1));
            cur = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 15) : $urandom_range(0, 4);
            rst = ($urandom_range(0, 19) == 0);
            exp_v = rst ? 8'h00 : ref_model(px, py, tx, ty, g, cur);
            step(rst, px, py, tx, ty, g, cur);
            check("rand_avail", availible_dir, exp_v[7:4]);
            check("rand_next", nextDirection, exp_v[3:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ghost_navigator.md
# ghost_navigator

Maze-navigation unit for ghost movement. It combines `valid_moves` (legal-direction lookup against an on-chip maze map) and `next_dir` (target-seeking direction choice). It sits between a ghost controller, which supplies position, target and current heading, and that controller's position/animation logic, which consumes the legal-move mask and the chosen heading. All outputs are registered on `Clk`.

## Interface

Parameters:
- `MAZE_FILE`, "maze.mem": `$readmemh` image, 31 rows × 28 columns, 2-bit cell code: 0 = open, 1 = wall, 2 = ghost door, 3 = wall.
- `MAZE_X0`, 72: screen X of maze column 0 left edge.
- `MAZE_Y0`, 0: screen Y of maze row 0 top edge.

Ports (one clock; reset is synchronous and active-high):
- `Clk` in 1: system clock, 50 MHz.
- `Reset` in 1: synchronous, active-high.
- `PosX`, `PosY` in 10: sprite top-left in screen pixels; sprite is 24×24.
- `is_Ghost` in 1: 1 lets door cells count as open.
- `targetX`, `targetY` in 10: target in the same sprite-coordinate convention.
- `currentDirection` in 4: 0 none, 1 left, 2 up, 3 right, 4 down.
- `availible_dir` out 4: legal-move mask; bit0 left, bit1 up, bit2 right, bit3 down.
- `nextDirection` out 4: chosen heading, same encoding as `currentDirection`.

## Operation

- Tile size is 12 px.
- Centre pixel: cx = PosX+12−MAZE_X0, cy = PosY+12−MAZE_Y0, both signed 11-bit.
- Tile coordinates: col = cx/12, row = cy/12. Offsets: ox = cx mod 12, oy = cy mod 12.
- A ghost is centred in X when ox==6 and in Y when oy==6.
- Cell lookup: combinational (asynchronous) ROM read. Open(c,r) is true when the code is 0, or when the code is 2 and `is_Ghost`=1.
- Column indices −1 and 28 on rows in range are open (tunnel). Any other out-of-range row or column is wall.
- Horizontal moves (left/right) require Y-centred; otherwise bits 0 and 2 are 0.
  - left: legal if ox>6, or Open(col−1,row).
  - right: legal if ox<6, or Open(col+1,row).
- Vertical moves (up/down) require X-centred; otherwise bits 1 and 3 are 0.
  - up: legal if oy>6, or Open(col,row−1).
  - down: legal if oy<6, or Open(col,row+1).
- Tunnel/off-maze region (cx<0 or col≥28): `availible_dir`=4'b0101 and `nextDirection`=`currentDirection`.
- Target tile: tc, tr come from `targetX`/`targetY` with the same formula. They are signed and are not clamped.
- Decision point: X-centred and Y-centred together.
  - When not at a decision point, `nextDirection`=`currentDirection`.
  - At a decision point, each legal direction except the reverse of `currentDirection` is a candidate.
  - Reverse pairs: 1↔3, 2↔4. Direction 0 has no reverse.
- Candidate scoring:
  - Score = (nc−tc)² + (nr−tr)², where (nc,nr) is the neighbour tile in that direction.
  - Arithmetic is unsigned 16-bit; deltas are signed 8-bit.
  - Lowest score wins.
  - Ties go by fixed priority: up, left, down, right.
- No candidate, but the reverse is legal: choose the reverse.
- No legal move at all: choose 0.
- Unknown `currentDirection` (5–15): treat as 0, so there is no reverse exclusion.

## Timing

- Single pipeline stage.
- Both outputs register the values computed from the inputs present at a `Clk` rising edge; they are valid after that edge. Latency is 1 cycle; throughput is 1 per cycle.
- No handshake; inputs are sampled every cycle.
- With `Reset` high at an edge: `availible_dir`=0 and `nextDirection`=0. Outputs hold 0 while `Reset` stays high.
- On the first edge after `Reset` falls, outputs reflect the inputs again.
- Reset mid-operation discards the in-flight result.
- Simultaneous input changes are treated as a single new sample.
- No state is kept apart from the output registers.
- ROM content is loaded at configuration and is unaffected by `Reset`.

## Test plan

Test maze: border cells are walls and the interior is open, except cell (5,4), which is a door (code 2), and cells (1,0) and (0,1), which are walls.

1. Reset: hold `Reset`=1 for 1 cycle with arbitrary inputs -> next cycle `availible_dir`=0 and `nextDirection`=0. After release, the outputs follow the inputs one cycle later.
2. Corner: PosX=78, PosY=6 (tile 1,1, centred), `currentDirection`=2 -> `availible_dir`=4'b0100 | 4'b1000 = 4'b1100 and `nextDirection`=3. Down is the reverse and is excluded.
3. Mid-corridor: PosX=81, PosY=6, `currentDirection`=3 -> `availible_dir`=4'b0101 and `nextDirection`=3.
4. Four-way choice at PosX=126, PosY=54 (tile 5,5), `currentDirection`=1, `is_Ghost`=1:
   - target PosX=126, PosY=6 (tile 5,1) -> `nextDirection`=2.
   - target tile (5,5) -> tie among up/left/down -> `nextDirection`=2.
   - target tile (2,5) -> `nextDirection`=1.
5. Door, tile (5,5), with `currentDirection`=4:
   - `is_Ghost`=0 -> bit1 of `availible_dir` is 0.
   - `is_Ghost`=1 -> bit1 is 1.
6. Tunnel: PosX=40, PosY=6 with `currentDirection`=1 -> `availible_dir`=4'b0101 and `nextDirection`=1. Wrapped PosX=1000 gives the same result.
